// File: rtl/temp_code_pkg.sv
// Shared thresholds and thermometer-code definitions for temp_threshold_encoder.
package temp_code_pkg;

    localparam int unsigned NUM_THRESH = 5;

    localparam int unsigned TH10 = 10;
    localparam int unsigned TH15 = 15;
    localparam int unsigned TH20 = 20;
    localparam int unsigned TH25 = 25;
    localparam int unsigned TH30 = 30;

    localparam int unsigned THRESH [NUM_THRESH] = '{TH10, TH15, TH20, TH25, TH30};

    // Bit i is the flag of threshold THRESH[i]; bit 0 is the 10 C flag.
    typedef logic [NUM_THRESH-1:0] therm_code_t;

    localparam therm_code_t CODE_NONE = 5'b00000;
    localparam therm_code_t CODE_10   = 5'b00001;
    localparam therm_code_t CODE_15   = 5'b00011;
    localparam therm_code_t CODE_20   = 5'b00111;
    localparam therm_code_t CODE_25   = 5'b01111;
    localparam therm_code_t CODE_30   = 5'b11111;

    // A flag survives only if every lower flag is also set.
    function automatic therm_code_t therm_mask(input therm_code_t ch);
        therm_code_t m;
        m[0] = ch[0];
        for (int i = 1; i < NUM_THRESH; i++) begin
            m[i] = ch[i] & m[i-1];
        end
        return m;
    endfunction

endpackage

// File: rtl/threshold_channel.sv
// One threshold flag with hysteresis and sample-count debounce; flag_c is the next flag value.
module threshold_channel #(
    parameter int unsigned TEMP_W   = 8,
    parameter int unsigned TH       = 10,
    parameter int unsigned HYST     = 2,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TEMP_W-1:0] temp,
    input  logic              sample_valid,
    input  logic              clear,
    output logic              flag_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [TEMP_W-1:0] TH_ON  = TEMP_W'(TH);
    localparam logic [TEMP_W-1:0] TH_OFF = TEMP_W'(TH - HYST);

    logic             flag_q;
    logic             flag_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             raw_c;

    // Set at TH, released only below TH-HYST; toggle after DEBOUNCE disagreeing samples.
    always_comb begin
        raw_c  = flag_q ? (temp >= TH_OFF) : (temp >= TH_ON);
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (sample_valid) begin
            if (raw_c == flag_q) begin
                cnt_d = '0;
            end else if (cnt_q >= CNT_W'(DEBOUNCE - 1)) begin
                flag_d = ~flag_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag_c = flag_d;

endmodule

// File: rtl/temp_threshold_encoder.sv
// Temperature samples to debounced thermometer flags t10..t30.
// Optional sample watchdog enabled by defining SAMPLE_WATCHDOG_EN.
module temp_threshold_encoder
    import temp_code_pkg::*;
#(
    parameter int unsigned TEMP_W   = 8,
    parameter int unsigned HYST     = 2,
    parameter int unsigned DEBOUNCE = 2
`ifdef SAMPLE_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT  = 100
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TEMP_W-1:0] temp,
    input  logic              sample_valid,
    output logic              t10,
    output logic              t15,
    output logic              t20,
    output logic              t25,
    output logic              t30,
    output logic              code_valid,
    output logic              stale
);

    therm_code_t ch_next_c;
    therm_code_t code_q;
    logic        code_valid_q;
    logic        clear_c;

    for (genvar i = 0; i < NUM_THRESH; i++) begin : g_ch
        threshold_channel #(
            .TEMP_W  (TEMP_W),
            .TH      (THRESH[i]),
            .HYST    (HYST),
            .DEBOUNCE(DEBOUNCE)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .temp        (temp),
            .sample_valid(sample_valid),
            .clear       (clear_c),
            .flag_c      (ch_next_c[i])
        );
    end

`ifdef SAMPLE_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            stale_q;

    // Fires on the idle edge that brings the watchdog to TIMEOUT.
    assign clear_c = !sample_valid && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else if (sample_valid) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            if (wd_q != WD_W'(TIMEOUT)) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (clear_c) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign stale = stale_q;
`else
    assign clear_c = 1'b0;
    assign stale   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q       <= CODE_NONE;
            code_valid_q <= 1'b0;
        end else begin
            code_q <= therm_mask(ch_next_c);
            if (sample_valid) begin
                code_valid_q <= 1'b1;
            end else if (clear_c) begin
                code_valid_q <= 1'b0;
            end
        end
    end

    assign t10        = code_q[0];
    assign t15        = code_q[1];
    assign t20        = code_q[2];
    assign t25        = code_q[3];
    assign t30        = code_q[4];
    assign code_valid = code_valid_q;

endmodule
